// File: rtl/fft8_rot_pkg.sv
// -----------------------------------------------------------------------------
// fft8_rot_pkg
// Shared types and constants for the 8-point FFT rotation scheduler.
//   state_e    : scheduler FSM states (IDLE, RUN)
//   MUL_LAT    : latency of the 0.7071 constant multiplier, in ED-enabled edges
//   TOK_DEPTH  : depth of the {valid, odd} mode-token pipe
//   w8_exp_t   : twiddle exponent e of W8^e = exp(-j*pi*e/4)
//   rot_mode_t : rotation mode decoded from e
//   tok_t      : token carried alongside each sample to the merge point
// -----------------------------------------------------------------------------
package fft8_rot_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int MUL_LAT   = 4;
  localparam int TOK_DEPTH = MUL_LAT + 1;

  typedef logic [2:0] w8_exp_t;

  // The exponent bits map directly onto the rotation:
  //   e[0] : odd exponent, goes through the pre-adder and the 0.7071 multiplier
  //   e[1] : extra -j factor (MPYJ for odd, swap/negate in the bypass for even)
  //   e[2] : overall negation
  typedef struct packed {
    logic odd;
    logic neg;
    logic rot_j;
  } rot_mode_t;

  typedef struct packed {
    logic valid;
    logic odd;
  } tok_t;

  function automatic rot_mode_t rot_mode(input w8_exp_t e);
    rot_mode_t m;
    m.odd   = e[0];
    m.rot_j = e[1];
    m.neg   = e[2];
    return m;
  endfunction

endpackage

// File: rtl/mpuc707.sv
// -----------------------------------------------------------------------------
// MPUC707
// Complex multiply by 0.7071 with optional extra -j factor.
//   CLK      : clock
//   ED       : enable; every stage is frozen when low
//   DS       : data strobe; DR/DI/MPYJ are captured on an ED edge with DS high
//   MPYJ     : when set, the result is additionally multiplied by -j
//   DR, DI   : signed operand
//   DOR, DOI : signed result, valid 3 enabled edges after the capture edge and
//              held until the next result replaces it
// Pipeline: capture -> product -> round -> output (4 registers from DR/DI).
// The constant is round(0.70710678 * 2^17); products are rounded to nearest.
// -----------------------------------------------------------------------------
module MPUC707 #(
  parameter int total_bits = 32
) (
  input  logic                         CLK,
  input  logic                         DS,
  input  logic                         ED,
  input  logic                         MPYJ,
  input  logic signed [total_bits-1:0] DR,
  input  logic signed [total_bits-1:0] DI,
  output logic signed [total_bits-1:0] DOR,
  output logic signed [total_bits-1:0] DOI
);

  localparam int                     PW   = total_bits + 18;
  localparam logic signed [17:0]     K707 = 18'sd92682;
  localparam logic signed [PW-1:0]   RND  = PW'(65536);

  logic signed [total_bits-1:0] a_re_q, a_re_d, a_im_q, a_im_d;
  logic signed [PW-1:0]         p_re_q, p_re_d, p_im_q, p_im_d;
  logic signed [total_bits-1:0] r_re_q, r_re_d, r_im_q, r_im_d;
  logic signed [total_bits-1:0] dor_q, dor_d, doi_q, doi_d;
  logic                         j1_q, j1_d, j2_q, j2_d, j3_q, j3_d;

  always_comb begin
    a_re_d = a_re_q;
    a_im_d = a_im_q;
    j1_d   = j1_q;
    p_re_d = p_re_q;
    p_im_d = p_im_q;
    j2_d   = j2_q;
    r_re_d = r_re_q;
    r_im_d = r_im_q;
    j3_d   = j3_q;
    dor_d  = dor_q;
    doi_d  = doi_q;
    if (ED) begin
      if (DS) begin
        a_re_d = DR;
        a_im_d = DI;
        j1_d   = MPYJ;
      end
      p_re_d = PW'(a_re_q) * PW'(K707);
      p_im_d = PW'(a_im_q) * PW'(K707);
      j2_d   = j1_q;
      r_re_d = total_bits'((p_re_q + RND) >>> 17);
      r_im_d = total_bits'((p_im_q + RND) >>> 17);
      j3_d   = j2_q;
      // (x + jy) * (-j) = y - jx
      dor_d  = j3_q ? r_im_q  : r_re_q;
      doi_d  = j3_q ? -r_re_q : r_im_q;
    end
  end

  // Pure datapath: results are only consumed when a token says so, so no reset.
  always_ff @(posedge CLK) begin
    a_re_q <= a_re_d;
    a_im_q <= a_im_d;
    j1_q   <= j1_d;
    p_re_q <= p_re_d;
    p_im_q <= p_im_d;
    j2_q   <= j2_d;
    r_re_q <= r_re_d;
    r_im_q <= r_im_d;
    j3_q   <= j3_d;
    dor_q  <= dor_d;
    doi_q  <= doi_d;
  end

  assign DOR = dor_q;
  assign DOI = doi_q;

endmodule

// File: rtl/rot_bypass_dly.sv
// -----------------------------------------------------------------------------
// rot_bypass_dly
// ED-gated complex delay line for the trivial-rotation (even exponent) path.
// Its depth equals the multiplier latency so both paths reach the merge point
// on the same ED-enabled edge.
//   clk, rst_n      : clock, asynchronous active-low reset
//   ed              : advance enable; the line is frozen when low
//   din_re, din_im  : sample entering the line
//   dout_re, dout_im: sample leaving the line DEPTH enabled edges later
// -----------------------------------------------------------------------------
module rot_bypass_dly #(
  parameter int W     = 18,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ed,
  input  logic signed [W-1:0] din_re,
  input  logic signed [W-1:0] din_im,
  output logic signed [W-1:0] dout_re,
  output logic signed [W-1:0] dout_im
);

  logic [DEPTH-1:0][W-1:0] re_q, re_d;
  logic [DEPTH-1:0][W-1:0] im_q, im_d;

  always_comb begin
    re_d = re_q;
    im_d = im_q;
    if (ed) begin
      re_d[0] = din_re;
      im_d[0] = din_im;
      for (int i = 1; i < DEPTH; i++) begin
        re_d[i] = re_q[i-1];
        im_d[i] = im_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_q <= '0;
      im_q <= '0;
    end else begin
      re_q <= re_d;
      im_q <= im_d;
    end
  end

  assign dout_re = $signed(re_q[DEPTH-1]);
  assign dout_im = $signed(im_q[DEPTH-1]);

endmodule

// File: rtl/fft8_rot_sched.sv
// -----------------------------------------------------------------------------
// fft8_rot_sched
// Applies W8^e = exp(-j*pi*e/4) to each accepted complex sample. Odd exponents
// go through a pre-adder and the shared 0.7071 multiplier; even exponents take
// a latency-matched trivial-rotation bypass. Both paths merge in order.
//   CLK, RSTN      : clock (rising edge), asynchronous active-low reset
//   ED             : global enable; all state frozen when low
//   IN_VLD/IN_RDY  : input handshake; a sample is accepted on an ED edge with
//                    IN_VLD & IN_RDY. IN_RDY depends only on internal state and
//                    is high on every other ED cycle (phase 0).
//   IN_SOF         : accepted sample is frame index 0 (restarts e = 0)
//   TW_STEP        : twiddle exponent step, latched with an accepted SOF sample
//   DR, DI         : signed input sample (NB bits)
//   OUT_VLD        : one ED-enabled cycle per accepted sample, 5 edges later
//   DOR, DOI       : signed rotated sample (NB+2 bits)
//   ERR            : sticky, set when a non-SOF sample is accepted in IDLE
// -----------------------------------------------------------------------------
module fft8_rot_sched
  import fft8_rot_pkg::*;
#(
  parameter int NB = 16
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 ED,
  input  logic                 IN_VLD,
  output logic                 IN_RDY,
  input  logic                 IN_SOF,
  input  logic [2:0]           TW_STEP,
  input  logic signed [NB-1:0] DR,
  input  logic signed [NB-1:0] DI,
  output logic                 OUT_VLD,
  output logic signed [NB+1:0] DOR,
  output logic signed [NB+1:0] DOI,
  output logic                 ERR
);

  localparam int W = NB + 2;

  // ---------------------------------------------------------------------------
  // Scheduler FSM
  // ---------------------------------------------------------------------------
  state_e    state_q, state_d;
  logic      phase_q, phase_d;
  logic [2:0] idx_q, idx_d;
  w8_exp_t   e_q, e_d;
  w8_exp_t   step_q, step_d;
  logic      err_q, err_d;

  logic      in_rdy;
  logic      acc;
  logic      take;
  logic      drop;
  w8_exp_t   cur_e;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      phase_q <= 1'b0;
      idx_q   <= 3'd0;
      e_q     <= 3'd0;
      step_q  <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      e_q     <= e_d;
      step_q  <= step_d;
      err_q   <= err_d;
    end
  end

  // The registers hold the exponent/index of the NEXT sample, so an accepted
  // SOF sample (which itself uses e = 0) leaves idx = 1, e = step behind.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    e_d     = e_q;
    step_d  = step_q;
    err_d   = err_q;
    if (ED) begin
      case (state_q)
        ST_IDLE: begin
          if (take) begin
            state_d = ST_RUN;
            phase_d = 1'b1;
            idx_d   = 3'd1;
            e_d     = TW_STEP;
            step_d  = TW_STEP;
          end
        end
        ST_RUN: begin
          phase_d = ~phase_q;
          if (take) begin
            if (IN_SOF) begin
              idx_d  = 3'd1;
              e_d    = TW_STEP;
              step_d = TW_STEP;
            end else begin
              idx_d = idx_q + 3'd1;
              e_d   = e_q + step_q;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (drop) err_d = 1'b1;
    end
  end

  // RSTN gates IN_RDY so the block never appears ready while held in reset.
  always_comb begin
    in_rdy = RSTN & ~phase_q;
    acc    = ED & IN_VLD & in_rdy;
    take   = acc & ((state_q == ST_RUN) | IN_SOF);
    drop   = acc & (state_q == ST_IDLE) & ~IN_SOF;
    cur_e  = IN_SOF ? 3'd0 : e_q;
  end

  // ---------------------------------------------------------------------------
  // Prep stage: pre-adder for odd exponents, trivial rotation for even ones.
  // Everything is widened to W bits first so that negating the most negative
  // input (or u = -2^NB) cannot wrap.
  // ---------------------------------------------------------------------------
  rot_mode_t           mode;
  logic signed [NB:0]  u_n, v_n;
  logic signed [W-1:0] dr_x, di_x, u_x, v_x;
  logic signed [W-1:0] base_re, base_im, rot_re, rot_im;

  always_comb begin
    mode = rot_mode(cur_e);
    u_n  = (NB+1)'(DR) + (NB+1)'(DI);
    v_n  = (NB+1)'(DI) - (NB+1)'(DR);
    dr_x = W'(DR);
    di_x = W'(DI);
    u_x  = W'(u_n);
    v_x  = W'(v_n);
    if (mode.odd) begin
      base_re = u_x;
      base_im = v_x;
    end else if (mode.rot_j) begin
      base_re = di_x;
      base_im = -dr_x;
    end else begin
      base_re = dr_x;
      base_im = di_x;
    end
    if (mode.neg) begin
      rot_re = -base_re;
      rot_im = -base_im;
    end else begin
      rot_re = base_re;
      rot_im = base_im;
    end
  end

  // ---------------------------------------------------------------------------
  // Prep registers, multiplier strobes, token pipe and output merge
  // ---------------------------------------------------------------------------
  logic signed [W-1:0]      prep_re_q, prep_re_d, prep_im_q, prep_im_d;
  logic                     mpyj_q, mpyj_d;
  logic                     ds_q, ds_d;
  tok_t [TOK_DEPTH-1:0]     tok_q, tok_d;
  logic                     out_vld_q, out_vld_d;
  logic signed [W-1:0]      dor_q, dor_d, doi_q, doi_d;
  logic signed [W-1:0]      mul_re, mul_im;
  logic signed [W-1:0]      byp_re, byp_im;

  always_comb begin
    prep_re_d = prep_re_q;
    prep_im_d = prep_im_q;
    mpyj_d    = mpyj_q;
    ds_d      = ds_q;
    tok_d     = tok_q;
    out_vld_d = out_vld_q;
    dor_d     = dor_q;
    doi_d     = doi_q;
    if (ED) begin
      // DS is high for exactly the one ED cycle after an odd accept.
      ds_d = take & mode.odd;
      if (take) begin
        prep_re_d = rot_re;
        prep_im_d = rot_im;
        mpyj_d    = mode.odd & mode.rot_j;
      end
      tok_d[0].valid = take;
      tok_d[0].odd   = mode.odd;
      for (int i = 1; i < TOK_DEPTH; i++) begin
        tok_d[i] = tok_q[i-1];
      end
      out_vld_d = tok_q[TOK_DEPTH-1].valid;
      if (tok_q[TOK_DEPTH-1].valid) begin
        dor_d = tok_q[TOK_DEPTH-1].odd ? mul_re : byp_re;
        doi_d = tok_q[TOK_DEPTH-1].odd ? mul_im : byp_im;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      prep_re_q <= '0;
      prep_im_q <= '0;
      mpyj_q    <= 1'b0;
      ds_q      <= 1'b0;
      tok_q     <= '0;
      out_vld_q <= 1'b0;
      dor_q     <= '0;
      doi_q     <= '0;
    end else begin
      prep_re_q <= prep_re_d;
      prep_im_q <= prep_im_d;
      mpyj_q    <= mpyj_d;
      ds_q      <= ds_d;
      tok_q     <= tok_d;
      out_vld_q <= out_vld_d;
      dor_q     <= dor_d;
      doi_q     <= doi_d;
    end
  end

  MPUC707 #(
    .total_bits(W)
  ) u_mpy (
    .CLK (CLK),
    .DS  (ds_q),
    .ED  (ED),
    .MPYJ(mpyj_q),
    .DR  (prep_re_q),
    .DI  (prep_im_q),
    .DOR (mul_re),
    .DOI (mul_im)
  );

  rot_bypass_dly #(
    .W    (W),
    .DEPTH(MUL_LAT)
  ) u_byp (
    .clk    (CLK),
    .rst_n  (RSTN),
    .ed     (ED),
    .din_re (prep_re_q),
    .din_im (prep_im_q),
    .dout_re(byp_re),
    .dout_im(byp_im)
  );

  assign IN_RDY  = in_rdy;
  assign OUT_VLD = out_vld_q;
  assign DOR     = dor_q;
  assign DOI     = doi_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_fft8_rot_sched.sv
// -----------------------------------------------------------------------------
// tb_fft8_rot_sched
// Drives fft8_rot_sched with directed and random frames. A reference model
// tracks readiness, frame exponents and the sticky error flag, and computes
// each expected output as a true complex rotation exp(-j*pi*e/4) in reals,
// due 5 ED-enabled edges after its accept.
// -----------------------------------------------------------------------------
module tb_fft8_rot_sched;

  localparam int NB = 16;

  logic                 CLK = 1'b0;
  logic                 RSTN;
  logic                 ED;
  logic                 IN_VLD;
  logic                 IN_RDY;
  logic                 IN_SOF;
  logic [2:0]           TW_STEP;
  logic signed [NB-1:0] DR, DI;
  logic                 OUT_VLD;
  logic signed [NB+1:0] DOR, DOI;
  logic                 ERR;

  fft8_rot_sched #(.NB(NB)) dut (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .ED     (ED),
    .IN_VLD (IN_VLD),
    .IN_RDY (IN_RDY),
    .IN_SOF (IN_SOF),
    .TW_STEP(TW_STEP),
    .DR     (DR),
    .DI     (DI),
    .OUT_VLD(OUT_VLD),
    .DOR    (DOR),
    .DOI    (DOI),
    .ERR    (ERR)
  );

  // clock / reset block
  always #5 CLK = ~CLK;

  // scoreboard
  typedef struct {
    int re;
    int im;
    int tol;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  bit run_m, phase_m, err_m, last_vld_m;
  int e_m, step_m;
  int ed_edges = 0;
  bit last_acc;
  int ed_mode = 0;
  bit ed_ph = 1'b1;
  int dut_out_cnt = 0;

  task automatic check_eq(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_tol(input string tag, input int obs, input int exp_v, input int tol);
    checks++;
    assert ((obs >= exp_v - tol) && (obs <= exp_v + tol)) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (+/-%0d)", tag, obs, exp_v, tol);
    end
  endtask

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  // (a + jb) * exp(-j*th) = (a*cos + b*sin) + j(b*cos - a*sin)
  function automatic exp_t ref_rot(input int a, input int b, input int e, input int due);
    exp_t r;
    real th, c, s;
    th    = 3.14159265358979 * e / 4.0;
    c     = $cos(th);
    s     = $sin(th);
    r.re  = rnd(a * c + b * s);
    r.im  = rnd(b * c - a * s);
    r.tol = (e % 2 == 1) ? 1 : 0;
    r.due = due;
    return r;
  endfunction

  task automatic get_ed(output logic ed);
    case (ed_mode)
      0: ed = 1'b1;
      1: begin
        ed    = ed_ph;
        ed_ph = ~ed_ph;
      end
      default: ed = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  // One clock: drive at the negedge, predict, then check after the next edge.
  task automatic cycle(input logic ed, input logic vld, input logic sof,
                       input logic [2:0] st, input logic signed [NB-1:0] dr,
                       input logic signed [NB-1:0] di);
    bit   acc;
    int   e_use;
    exp_t x;
    ED      = ed;
    IN_VLD  = vld;
    IN_SOF  = sof;
    TW_STEP = st;
    DR      = dr;
    DI      = di;
    #1;
    check_eq("in_rdy", IN_RDY, !phase_m);
    acc      = ed && vld && !phase_m;
    last_acc = acc;
    if (ed) ed_edges++;
    if (acc) begin
      if (!run_m && !sof) begin
        err_m = 1'b1;
      end else begin
        if (sof) begin
          e_use  = 0;
          step_m = int'(st);
          run_m  = 1'b1;
        end else begin
          e_use = e_m;
        end
        x = ref_rot(int'(dr), int'(di), e_use, ed_edges + 5);
        exp_q.push_back(x);
        e_m = (e_use + step_m) % 8;
      end
    end
    if (ed && run_m) phase_m = !phase_m;
    @(posedge CLK);
    @(negedge CLK);
    if (ed) begin
      if (OUT_VLD === 1'b1) dut_out_cnt++;
      if (exp_q.size() > 0 && exp_q[0].due == ed_edges) begin
        x = exp_q.pop_front();
        check_eq("out_vld", OUT_VLD, 1);
        check_tol("dor", int'(DOR), x.re, x.tol);
        check_tol("doi", int'(DOI), x.im, x.tol);
        last_vld_m = 1'b1;
      end else begin
        check_eq("out_vld_idle", OUT_VLD, 0);
        last_vld_m = 1'b0;
      end
    end else begin
      check_eq("out_vld_hold", OUT_VLD, last_vld_m);
    end
    check_eq("err", ERR, err_m);
  endtask

  // Driver: hold IN_VLD until the model sees the handshake (bounded).
  task automatic send(input logic sof, input logic [2:0] st,
                      input logic signed [NB-1:0] dr, input logic signed [NB-1:0] di);
    logic ed;
    bit   done;
    done = 1'b0;
    for (int k = 0; k < 32 && !done; k++) begin
      get_ed(ed);
      cycle(ed, 1'b1, sof, st, dr, di);
      done = last_acc;
    end
    check_eq("send_accept", done, 1);
  endtask

  task automatic idle(input int n);
    logic ed;
    for (int k = 0; k < n; k++) begin
      get_ed(ed);
      cycle(ed, 1'b0, 1'b0, 3'd0, '0, '0);
    end
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    #1;
    check_eq("rst_out_vld", OUT_VLD, 0);
    check_eq("rst_dor", DOR, 0);
    check_eq("rst_doi", DOI, 0);
    check_eq("rst_err", ERR, 0);
    check_eq("rst_in_rdy", IN_RDY, 0);
    run_m      = 1'b0;
    phase_m    = 1'b0;
    err_m      = 1'b0;
    last_vld_m = 1'b0;
    e_m        = 0;
    step_m     = 0;
    exp_q.delete();
    repeat (2) @(negedge CLK);
    check_eq("rst_hold_out_vld", OUT_VLD, 0);
    RSTN = 1'b1;
  endtask

  function automatic logic signed [NB-1:0] rand_s();
    return NB'($urandom);
  endfunction

  int cnt0;

  initial begin
    ED      = 1'b0;
    IN_VLD  = 1'b0;
    IN_SOF  = 1'b0;
    TW_STEP = 3'd0;
    DR      = '0;
    DI      = '0;
    do_reset();

    // step 1: one frame of (1000, 0), back to back
    for (int i = 0; i < 8; i++) send(i == 0, 3'd1, 16'sd1000, 16'sd0);
    idle(8);

    // step 0: random samples pass unchanged, back to back
    for (int i = 0; i < 8; i++) send(i == 0, 3'd0, rand_s(), rand_s());
    idle(8);

    // ED toggling 1-0: same frame, same values, 8 outputs
    ed_mode = 1;
    ed_ph   = 1'b1;
    cnt0    = dut_out_cnt;
    for (int i = 0; i < 8; i++) send(i == 0, 3'd1, 16'sd1000, 16'sd0);
    idle(16);
    check_eq("ed_toggle_out_cnt", dut_out_cnt - cnt0, 8);
    ed_mode = 0;

    // step 3 with gaps, restart at idx 4
    for (int i = 0; i < 8; i++) begin
      send(i == 0 || i == 4, 3'd3, rand_s(), rand_s());
      idle($urandom_range(0, 3));
    end
    idle(8);

    // non-SOF sample in IDLE is dropped and sets ERR; a later SOF still works
    do_reset();
    send(1'b0, 3'd1, 16'sd123, 16'sd456);
    idle(8);
    check_eq("err_set", ERR, 1);
    for (int i = 0; i < 8; i++) send(i == 0, 3'd2, rand_s(), rand_s());
    idle(8);
    check_eq("err_sticky", ERR, 1);

    // most negative input at e = 2 and e = 4 must not wrap
    do_reset();
    send(1'b1, 3'd2, -16'sd32768, -16'sd32768);
    send(1'b0, 3'd2, -16'sd32768, -16'sd32768);
    send(1'b0, 3'd2, -16'sd32768, -16'sd32768);
    idle(8);

    // reset with two samples in flight discards them
    send(1'b1, 3'd1, rand_s(), rand_s());
    send(1'b0, 3'd1, rand_s(), rand_s());
    do_reset();
    idle(10);
    for (int i = 0; i < 4; i++) send(i == 0, 3'd5, rand_s(), rand_s());
    idle(8);

    // random ED, gaps, steps and restarts
    ed_mode = 2;
    for (int i = 0; i < 60; i++) begin
      send(i == 0 || $urandom_range(0, 9) == 0, 3'($urandom_range(0, 7)), rand_s(), rand_s());
      idle($urandom_range(0, 2));
    end
    ed_mode = 0;
    idle(10);
    check_eq("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
